// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared constants and state encoding for the 8-to-3 serializing encoder
package enc_pkg;

    localparam int IN_W  = 8;
    localparam int OUT_W = $clog2(IN_W);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/dec3to8_case.sv
// rtl/dec3to8_case.sv - 3-to-8 one-hot decoder with enable
module dec3to8_case (
    input  logic [2:0] in,
    input  logic       en,
    output logic [7:0] out
);

    always_comb begin
        out = 8'h00;
        if (en) begin
            case (in)
                3'd0: out = 8'b0000_0001;
                3'd1: out = 8'b0000_0010;
                3'd2: out = 8'b0000_0100;
                3'd3: out = 8'b0000_1000;
                3'd4: out = 8'b0001_0000;
                3'd5: out = 8'b0010_0000;
                3'd6: out = 8'b0100_0000;
                default: out = 8'b1000_0000;
            endcase
        end
    end

endmodule

// File: rtl/lsb_prio_enc8.sv
// rtl/lsb_prio_enc8.sv - lowest-set-bit index and single-bit detect for an 8-bit vector
module lsb_prio_enc8 (
    input  logic [enc_pkg::IN_W-1:0]  pending,
    output logic [enc_pkg::OUT_W-1:0] out,
    output logic                      out_last
);

    // Scan from the top down so the lowest set bit is the last to write.
    always_comb begin
        out = '0;
        for (int i = enc_pkg::IN_W - 1; i >= 0; i--) begin
            if (pending[i]) begin
                out = enc_pkg::OUT_W'(i);
            end
        end
    end

    assign out_last = (pending != '0) && ((pending & (pending - 1'b1)) == '0);

endmodule

// File: rtl/enc8to3_seq.sv
// rtl/enc8to3_seq.sv - captures a multi-hot request vector and streams out each set-bit index, LSB first
module enc8to3_seq
    import enc_pkg::state_t;
    import enc_pkg::ST_IDLE;
    import enc_pkg::ST_EMIT;
#(
    parameter int IN_W = enc_pkg::IN_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [IN_W-1:0]           in,
    input  logic                      en,
    output logic                      in_ready,
    output logic [enc_pkg::OUT_W-1:0] out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      err
);

    state_t          state, state_nxt;
    logic [IN_W-1:0] pending, pending_nxt;
    logic            err_nxt;
    logic [IN_W-1:0] clear_mask;

    lsb_prio_enc8 u_prio (
        .pending  (pending),
        .out      (out),
        .out_last (out_last)
    );

    dec3to8_case u_clear (
        .in  (out),
        .en  (1'b1),
        .out (clear_mask)
    );

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_EMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            pending <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            err     <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        err_nxt     = err;
        case (state)
            ST_IDLE: begin
                if (en && (in != '0)) begin
                    pending_nxt = in;
                    state_nxt   = ST_EMIT;
                end
            end
            ST_EMIT: begin
                // A load strobe while busy is dropped, even on the final transfer cycle.
                if (en) begin
                    err_nxt = 1'b1;
                end
                if (out_ready) begin
                    pending_nxt = pending & ~clear_mask;
                    if (out_last) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                pending_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_enc8to3_seq.sv
// tb/tb_enc8to3_seq.sv - directed self-checking bench for enc8to3_seq
module tb_enc8to3_seq;

    logic       clk;
    logic       rst_n;
    logic [7:0] in;
    logic       en;
    logic       in_ready;
    logic [2:0] out;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       err;

    int checks   = 0;
    int failures = 0;

    enc8to3_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .en        (en),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        en = 1'b1;
        in = v;
        step();
        en = 1'b0;
        in = 8'h00;
    endtask

    task automatic expect_emit(input string tag, input logic [2:0] idx, input logic last);
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_out"}, out, idx);
        check({tag, "_last"}, out_last, last);
        check({tag, "_in_ready"}, in_ready, 1'b0);
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_valid"}, out_valid, 1'b0);
        check({tag, "_in_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        in        = 8'h00;
        out_ready = 1'b0;
        repeat (3) step();
        check("rst_hold_valid", out_valid, 1'b0);
        check("rst_hold_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        step();
        check("rst_valid", out_valid, 1'b0);
        check("rst_out", out, 3'd0);
        check("rst_last", out_last, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);

        // one-hot sweep
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            load(8'(1 << k));
            expect_emit($sformatf("onehot%0d", k), 3'(k), 1'b1);
            step();
            expect_idle($sformatf("onehot%0d_done", k));
        end

        // multi-hot 1000_0101 -> 0, 2, 7
        load(8'b1000_0101);
        expect_emit("multi_a", 3'd0, 1'b0);
        step();
        expect_emit("multi_b", 3'd2, 1'b0);
        step();
        expect_emit("multi_c", 3'd7, 1'b1);
        step();
        expect_idle("multi_done");

        // backpressure 0001_0010
        out_ready = 1'b0;
        load(8'b0001_0010);
        for (int c = 0; c < 3; c++) begin
            expect_emit($sformatf("bp_hold%0d", c), 3'd1, 1'b0);
            step();
        end
        expect_emit("bp_hold_end", 3'd1, 1'b0);
        out_ready = 1'b1;
        step();
        expect_emit("bp_second", 3'd4, 1'b1);
        step();
        expect_idle("bp_done");

        // zero load
        load(8'h00);
        expect_idle("zero_load");
        check("zero_load_err", err, 1'b0);
        step();
        expect_idle("zero_load_later");

        // busy load during emission of 8'h03
        out_ready = 1'b0;
        load(8'h03);
        expect_emit("busy_first", 3'd0, 1'b0);
        load(8'h0F);
        expect_emit("busy_after_load", 3'd0, 1'b0);
        check("busy_err", err, 1'b1);
        out_ready = 1'b1;
        step();
        expect_emit("busy_second", 3'd1, 1'b1);
        step();
        expect_idle("busy_done");
        check("busy_err_sticky", err, 1'b1);
        load(8'h01);
        expect_emit("post_busy", 3'd0, 1'b1);
        step();
        check("busy_err_sticky2", err, 1'b1);

        // reset mid-operation
        load(8'hFF);
        expect_emit("ff_first", 3'd0, 1'b0);
        step();
        expect_emit("ff_second", 3'd1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_err", err, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_out", out, 3'd0);
        step();
        rst_n = 1'b1;
        step();
        expect_idle("midrst_released");
        load(8'h80);
        expect_emit("post_rst", 3'd7, 1'b1);
        // load attempt on the final transfer cycle still flags err
        en = 1'b1;
        in = 8'h0F;
        step();
        en = 1'b0;
        in = 8'h00;
        expect_idle("final_xfer_busy");
        check("final_xfer_err", err, 1'b1);
        step();
        expect_idle("final_xfer_no_load");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
